// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit RAM controller:
//   - lsu_funct3_e : access size/sign encodings seen on the core funct3 field
//   - lsu_state_e  : controller FSM states
//   - lane constants and byte-enable masks
//   - f_req_illegal: classifies a request as misaligned/illegal
// ----------------------------------------------------------------------------
package lsu_pkg;

   localparam int LANE_W = 8;   // bits per byte lane
   localparam int LANE_N = 4;   // byte lanes per 32-bit word

   localparam logic [3:0] BE_NONE  = 4'h0;
   localparam logic [3:0] BE_BYTE0 = 4'h1;
   localparam logic [3:0] BE_HALF0 = 4'h3;
   localparam logic [3:0] BE_WORD  = 4'hF;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } lsu_funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DATA   = 2'd2,
      ST_WRITE  = 2'd3
   } lsu_state_e;

   // 1 when the request must be rejected: unknown size code, unsigned
   // size on a store, or an address not aligned to the access size.
   function automatic logic f_req_illegal(input logic [2:0] f3,
                                          input logic       is_store,
                                          input logic [1:0] off);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = off[0];
         F3_W:    bad = (off != 2'b00);
         F3_BU:   bad = is_store;
         F3_HU:   bad = is_store | off[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the LSU RAM controller.
//   i_funct3 : access size/sign code
//   i_off    : byte offset inside the word (addr[1:0])
//   i_word   : word read from RAM (load source / read-modify-write base)
//   i_wdata  : right-aligned store data from the core
//   o_load   : extracted and sign/zero-extended load result
//   o_merge  : i_word with the store lanes replaced by i_wdata
//   o_lanes  : store data shifted onto its byte lanes
//   o_be     : byte-enable mask of the store lanes (0 for load-only codes)
// Little-endian: offset k selects bits 8k+7:8k.
// ----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
#(
   parameter int ANCHO = 32
) (
   input  logic [2:0]       i_funct3,
   input  logic [1:0]       i_off,
   input  logic [ANCHO-1:0] i_word,
   input  logic [ANCHO-1:0] i_wdata,
   output logic [ANCHO-1:0] o_load,
   output logic [ANCHO-1:0] o_merge,
   output logic [ANCHO-1:0] o_lanes,
   output logic [3:0]       o_be
);

   logic [4:0]       w_shamt;
   logic [ANCHO-1:0] w_down;
   logic [ANCHO-1:0] w_wdata_m;
   logic [ANCHO-1:0] w_mask;

   assign w_shamt = {i_off, 3'b000};
   assign w_down  = i_word >> w_shamt;

   // Load extraction: bring the addressed lanes down to bit 0, then extend.
   always_comb begin
      o_load = i_word;
      case (i_funct3)
         F3_B:    o_load = {{(ANCHO-8){w_down[7]}}, w_down[7:0]};
         F3_H:    o_load = {{(ANCHO-16){w_down[15]}}, w_down[15:0]};
         F3_BU:   o_load = {{(ANCHO-8){1'b0}}, w_down[7:0]};
         F3_HU:   o_load = {{(ANCHO-16){1'b0}}, w_down[15:0]};
         default: o_load = i_word;
      endcase
   end

   // Store lanes: trim data to the access size before shifting so stray
   // upper bits of a byte/half store never land in neighbouring lanes.
   always_comb begin
      w_wdata_m = i_wdata;
      o_be      = BE_NONE;
      case (i_funct3)
         F3_B: begin
            w_wdata_m = {{(ANCHO-8){1'b0}}, i_wdata[7:0]};
            o_be      = BE_BYTE0 << i_off;
         end
         F3_H: begin
            w_wdata_m = {{(ANCHO-16){1'b0}}, i_wdata[15:0]};
            o_be      = BE_HALF0 << i_off;
         end
         F3_W: begin
            w_wdata_m = i_wdata;
            o_be      = BE_WORD;
         end
         default: begin
            w_wdata_m = i_wdata;
            o_be      = BE_NONE;
         end
      endcase
   end

   assign o_lanes = w_wdata_m << w_shamt;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < LANE_N; i++) begin
         w_mask[i*LANE_W +: LANE_W] = {LANE_W{o_be[i]}};
      end
   end

   assign o_merge = (i_word & ~w_mask) | (o_lanes & w_mask);

endmodule

// File: rtl/lsu_ram_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ram_ctrl
// Bridges a core load/store request port to a synchronous single-port RAM
// (address/data/write-enable sampled at posedge, dout valid one cycle later).
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   req, we, funct3      : request (taken when req && ready), store flag, size
//   addr, wdata          : byte address, right-aligned store data
//   ready                : high only while IDLE
//   ack                  : one-cycle pulse, store completed
//   rvalid, rdata        : one-cycle pulse, extended load result (held)
//   err                  : one-cycle pulse, misaligned/illegal request
//   ram_we/addr/din/dout : RAM port (outputs registered)
//   ram_be               : byte enables, only with LSU_BYTE_WE_EN
//   o_dbg_state          : current FSM state
//
// Build option: define LSU_BYTE_WE_EN for a byte-enabled RAM; sub-word stores
// then become a single write. Without it, sub-word stores read-modify-write.
//
// Handshake: a request is taken at a rising edge where req && ready; the
// core holds req and its fields until then. ack/rvalid/err pulse for exactly
// one cycle, in which ready is already 1 so the next request can be taken.
// ----------------------------------------------------------------------------
module lsu_ram_ctrl
   import lsu_pkg::*;
#(
   parameter  int ANCHO = 32,
   parameter  int LARGO = 1024,
   localparam int AW    = $clog2(LARGO)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             we,
   input  logic [2:0]       funct3,
   input  logic [31:0]      addr,
   input  logic [ANCHO-1:0] wdata,
   output logic             ready,
   output logic             ack,
   output logic             rvalid,
   output logic [ANCHO-1:0] rdata,
   output logic             err,
   output logic             ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [ANCHO-1:0] ram_din,
`ifdef LSU_BYTE_WE_EN
   output logic [3:0]       ram_be,
`endif
   input  logic [ANCHO-1:0] ram_dout,
   output logic [1:0]       o_dbg_state
);

   lsu_state_e       r_state;
   logic [2:0]       r_f3;
   logic [1:0]       r_off;
   logic [ANCHO-1:0] r_wdata;
   logic             r_is_store;
   logic             r_ram_we;
   logic [AW-1:0]    r_ram_addr;
   logic [ANCHO-1:0] r_ram_din;
   logic [3:0]       r_ram_be;
   logic             r_ack;
   logic             r_rvalid;
   logic             r_err;
   logic [ANCHO-1:0] r_rdata;

   lsu_state_e       w_state_nxt;
   logic [2:0]       w_f3_nxt;
   logic [1:0]       w_off_nxt;
   logic [ANCHO-1:0] w_wdata_nxt;
   logic             w_is_store_nxt;
   logic             w_ram_we_nxt;
   logic [AW-1:0]    w_ram_addr_nxt;
   logic [ANCHO-1:0] w_ram_din_nxt;
   logic [3:0]       w_ram_be_nxt;
   logic             w_ack_nxt;
   logic             w_rvalid_nxt;
   logic             w_err_nxt;
   logic [ANCHO-1:0] w_rdata_nxt;

   logic             w_idle;
   logic             w_take;
   logic             w_illegal;
   logic [2:0]       w_al_f3;
   logic [1:0]       w_al_off;
   logic [ANCHO-1:0] w_al_wdata;
   logic [ANCHO-1:0] w_load;
   logic [ANCHO-1:0] w_merge;
   logic [ANCHO-1:0] w_lanes;
   logic [3:0]       w_be;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_take    = req && w_idle;
   assign w_illegal = f_req_illegal(funct3, we, addr[1:0]);

   // In IDLE the aligner looks at the live request (byte-enabled stores are
   // laned at accept); afterwards it works on the captured request fields.
   assign w_al_f3    = w_idle ? funct3    : r_f3;
   assign w_al_off   = w_idle ? addr[1:0] : r_off;
   assign w_al_wdata = w_idle ? wdata     : r_wdata;

   lsu_align #(.ANCHO(ANCHO)) u_align (
      .i_funct3 (w_al_f3),
      .i_off    (w_al_off),
      .i_word   (ram_dout),
      .i_wdata  (w_al_wdata),
      .o_load   (w_load),
      .o_merge  (w_merge),
      .o_lanes  (w_lanes),
      .o_be     (w_be)
   );

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_f3_nxt       = r_f3;
      w_off_nxt      = r_off;
      w_wdata_nxt    = r_wdata;
      w_is_store_nxt = r_is_store;
      w_ram_we_nxt   = 1'b0;
      w_ram_addr_nxt = r_ram_addr;
      w_ram_din_nxt  = r_ram_din;
      w_ram_be_nxt   = BE_NONE;
      w_ack_nxt      = 1'b0;
      w_rvalid_nxt   = 1'b0;
      w_err_nxt      = 1'b0;
      w_rdata_nxt    = r_rdata;

      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               if (w_illegal) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_f3_nxt       = funct3;
                  w_off_nxt      = addr[1:0];
                  w_wdata_nxt    = wdata;
                  w_is_store_nxt = we;
                  // Upper address bits are ignored: the index wraps.
                  w_ram_addr_nxt = addr[AW+1:2];
                  if (we && (funct3 == F3_W)) begin
                     w_state_nxt   = ST_WRITE;
                     w_ram_we_nxt  = 1'b1;
                     w_ram_din_nxt = wdata;
                     w_ram_be_nxt  = BE_WORD;
                  end else if (we) begin
`ifdef LSU_BYTE_WE_EN
                     w_state_nxt   = ST_WRITE;
                     w_ram_we_nxt  = 1'b1;
                     w_ram_din_nxt = w_lanes;
                     w_ram_be_nxt  = w_be;
`else
                     w_state_nxt   = ST_ACCESS;
`endif
                  end else begin
                     w_state_nxt = ST_ACCESS;
                  end
               end
            end
         end

         // RAM samples the address during this cycle.
         ST_ACCESS: begin
            w_state_nxt = ST_DATA;
         end

         // ram_dout now holds the addressed word.
         ST_DATA: begin
            if (r_is_store) begin
               w_state_nxt   = ST_WRITE;
               w_ram_we_nxt  = 1'b1;
               w_ram_din_nxt = w_merge;
               w_ram_be_nxt  = BE_WORD;
            end else begin
               w_state_nxt  = ST_IDLE;
               w_rdata_nxt  = w_load;
               w_rvalid_nxt = 1'b1;
            end
         end

         // RAM performs the write at the end of this cycle.
         ST_WRITE: begin
            w_state_nxt = ST_IDLE;
            w_ack_nxt   = 1'b1;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_f3       <= '0;
         r_off      <= '0;
         r_wdata    <= '0;
         r_is_store <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_ram_be   <= BE_NONE;
         r_ack      <= 1'b0;
         r_rvalid   <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_f3       <= w_f3_nxt;
         r_off      <= w_off_nxt;
         r_wdata    <= w_wdata_nxt;
         r_is_store <= w_is_store_nxt;
         r_ram_we   <= w_ram_we_nxt;
         r_ram_addr <= w_ram_addr_nxt;
         r_ram_din  <= w_ram_din_nxt;
         r_ram_be   <= w_ram_be_nxt;
         r_ack      <= w_ack_nxt;
         r_rvalid   <= w_rvalid_nxt;
         r_err      <= w_err_nxt;
         r_rdata    <= w_rdata_nxt;
      end
   end

   assign ready       = w_idle;
   assign ack         = r_ack;
   assign rvalid      = r_rvalid;
   assign err         = r_err;
   assign rdata       = r_rdata;
   assign ram_we      = r_ram_we;
   assign ram_addr    = r_ram_addr;
   assign ram_din     = r_ram_din;
   assign o_dbg_state = r_state;

`ifdef LSU_BYTE_WE_EN
   assign ram_be = r_ram_be;
   logic w_unused;
   assign w_unused = ^{addr[31:AW+2], w_merge};
`else
   logic w_unused;
   assign w_unused = ^{addr[31:AW+2], w_lanes, w_be, r_ram_be};
`endif

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_ram_ctrl
// Bench for lsu_ram_ctrl: a behavioural synchronous RAM, directed scenarios
// for the documented cases and a randomized load/store mix, all compared
// against a byte-level memory model and latency rules kept in the bench.
// ----------------------------------------------------------------------------
module tb_lsu_ram_ctrl;

  localparam int ANCHO = 32;
  localparam int LARGO = 1024;
  localparam int AW    = $clog2(LARGO);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             req = 1'b0;
  logic             we = 1'b0;
  logic [2:0]       funct3 = 3'b000;
  logic [31:0]      addr = 32'h0;
  logic [ANCHO-1:0] wdata = '0;
  logic             ready, ack, rvalid, err, ram_we;
  logic [ANCHO-1:0] rdata, ram_din;
  logic [AW-1:0]    ram_addr;
  logic [ANCHO-1:0] ram_dout = '0;
  logic [1:0]       dbg_state;
`ifdef LSU_BYTE_WE_EN
  logic [3:0]       ram_be;
`endif

  lsu_ram_ctrl #(.ANCHO(ANCHO), .LARGO(LARGO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .ack        (ack),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .err        (err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
`ifdef LSU_BYTE_WE_EN
    .ram_be     (ram_be),
`endif
    .ram_dout   (ram_dout),
    .o_dbg_state(dbg_state)
  );

  // ---------------- synchronous RAM (read-first) ----------------
  logic [31:0] ram [LARGO] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_we) begin
`ifdef LSU_BYTE_WE_EN
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
`else
      ram[ram_addr] <= ram_din;
`endif
    end
    ram_dout <= ram[ram_addr];
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [LARGO];
  logic [31:0] exp_rdata_hold;
  logic [31:0] exp_q [$];     // expected load results, in issue order

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, expv, $time);
  endtask

  function automatic bit m_illegal(input logic [2:0] f3, input logic st, input logic [31:0] a);
    case (f3)
      3'd0: return 1'b0;
      3'd1: return a[0];
      3'd2: return a[1:0] != 2'd0;
      3'd4: return st;
      3'd5: return st || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a >> 2) % LARGO);
  endfunction

  // Byte-by-byte store into the model memory.
  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int idx, off;
    logic [31:0] w;
    idx = m_index(a);
    off = int'(a[1:0]);
    w = exp_mem[idx];
    for (int i = 0; i < m_size(f3); i++)
      w[8*(off+i) +: 8] = d[8*i +: 8];
    exp_mem[idx] = w;
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    v = exp_mem[m_index(a)] >> (8 * int'(a[1:0]));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Edges from accept to the visible response pulse.
  function automatic int m_latency(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (m_illegal(f3, st, a)) return 0;
    if (!st) return 2;
    if (f3 == 3'd2) return 1;
`ifdef LSU_BYTE_WE_EN
    return 1;
`else
    return 3;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic op_we, input logic [2:0] op_f3,
                       input logic [31:0] op_addr, input logic [31:0] op_wdata);
    int n, we_cnt, lat;
    bit bad;
    bad = m_illegal(op_f3, op_we, op_addr);
    lat = m_latency(op_we, op_f3, op_addr);
    @(negedge clk);
    req = 1'b1; we = op_we; funct3 = op_f3; addr = op_addr; wdata = op_wdata;
    check("ready_before_accept", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    n = 0; we_cnt = 0;
    while (!(ack || rvalid || err) && n < 20) begin
      we_cnt += int'(ram_we);
      // Junk on the request port while busy must be ignored.
      req = 1'($urandom_range(0, 1)); we = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    we_cnt += int'(ram_we);
    if (n >= 20) check("response_timeout", 32'(n), 32'(lat));
    check("latency",    32'(n),      32'(lat));
    check("ram_we_cnt", 32'(we_cnt), (op_we && !bad) ? 32'd1 : 32'd0);
    check("err",        {31'b0, err},    {31'b0, bad});
    check("ack",        {31'b0, ack},    {31'b0, op_we && !bad});
    check("rvalid",     {31'b0, rvalid}, {31'b0, !op_we && !bad});
    check("ready_resp", {31'b0, ready},  32'd1);
    if (!bad && !op_we) begin
      exp_q.push_back(m_load(op_f3, op_addr));
      exp_rdata_hold = exp_q.pop_front();
      check("rdata", rdata, exp_rdata_hold);
    end else begin
      check("rdata_held", rdata, exp_rdata_hold);
    end
    if (!bad && op_we) m_store(op_f3, op_addr, op_wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    {31'b0, ready},  32'd1);
    check({tag, "_ack"},      {31'b0, ack},    32'd0);
    check({tag, "_rvalid"},   {31'b0, rvalid}, 32'd0);
    check({tag, "_err"},      {31'b0, err},    32'd0);
    check({tag, "_rdata"},    rdata,           32'd0);
    check({tag, "_ram_we"},   {31'b0, ram_we}, 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr),   32'd0);
    check({tag, "_ram_din"},  ram_din,         32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < LARGO; i++) exp_mem[i] = 32'h0;
    exp_rdata_hold = 32'h0;

    // reset
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    // word store / load
    do_op(1'b1, 3'd2, 32'h34, 32'hA234_5678);
    check("ram13_sw", ram[13], 32'hA234_5678);
    do_op(1'b0, 3'd2, 32'h34, 32'h0);
    check("lw34", rdata, 32'hA234_5678);

    // byte store and byte loads
    do_op(1'b1, 3'd0, 32'h35, 32'h0000_00FF);
    check("ram13_sb", ram[13], 32'hA234_FF78);
    do_op(1'b0, 3'd0, 32'h35, 32'h0);
    check("lb35", rdata, 32'hFFFF_FFFF);
    do_op(1'b0, 3'd4, 32'h35, 32'h0);
    check("lbu35", rdata, 32'h0000_00FF);

    // half store and half loads
    do_op(1'b1, 3'd2, 32'h40, 32'h0);
    do_op(1'b1, 3'd1, 32'h42, 32'h0000_8001);
    check("ram16_sh", ram[16], 32'h8001_0000);
    do_op(1'b0, 3'd1, 32'h42, 32'h0);
    check("lh42", rdata, 32'hFFFF_8001);
    do_op(1'b0, 3'd5, 32'h42, 32'h0);
    check("lhu42", rdata, 32'h0000_8001);

    // misaligned requests
    do_op(1'b0, 3'd2, 32'h41, 32'h0);
    do_op(1'b1, 3'd1, 32'h43, 32'hFFFF_FFFF);
    do_op(1'b1, 3'd4, 32'h44, 32'h1);
    do_op(1'b0, 3'd3, 32'h44, 32'h0);
    check("ram16_after_err", ram[16], 32'h8001_0000);

    // reset while the byte store is writing
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h35; wdata = 32'h0000_0011;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (!ram_we && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_test_saw_write", {31'b0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1 check("ram_we_drops", {31'b0, ram_we}, 32'd0);
    @(posedge clk); #1;
    check("ram13_untouched", ram[13], exp_mem[13]);
    check_reset_outputs("rst2");
    exp_rdata_hold = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    do_op(1'b1, 3'd2, 32'h1000, 32'hCAFE_0001);
    check("ram0_wrap", ram[0], 32'hCAFE_0001);
    do_op(1'b0, 3'd2, 32'h0, 32'h0);

    // randomized mix over a small window so loads hit earlier stores
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
          | 32'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // final memory image
    for (int i = 0; i < 32; i++) check("final_mem", ram[i], exp_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lsu_ram_ctrl.md
LSU_RAM_CTRL -- requirements
Module: lsu_ram_ctrl

Interface
REQ-001 SHALL have parameter ANCHO, default 32, data width in bits; only 32 is supported.
REQ-002 SHALL have parameter LARGO, default 1024, RAM depth in words; a power of two; index width AW = $clog2(LARGO).
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req  in  1  core request; accepted when req && ready.
REQ-006 we  in  1  1 = store, 0 = load; sampled at accept.
REQ-007 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  ANCHO  store data, right-aligned.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 ack  out  1  one-cycle pulse, store completed.
REQ-012 rvalid  out  1  one-cycle pulse, rdata valid.
REQ-013 rdata  out  ANCHO  extended load result, held until next rvalid.
REQ-014 err  out  1  one-cycle pulse, misaligned or illegal request.
REQ-015 ram_we, ram_addr[AW-1:0], ram_din[ANCHO-1:0]  out  drive the RAM write_enable/addr/din; ram_dout[ANCHO-1:0] in, from RAM dout.

Function
REQ-016 The RAM SHALL be treated as synchronous: addr/din/write_enable sampled at posedge; dout valid one cycle later.
REQ-017 Word index SHALL be addr[AW+1:2]; upper address bits ignored (0x1000 wraps to index 0 at LARGO=1024).
REQ-018 Byte lanes SHALL be little-endian: addr[1:0]=k selects bits 8k+7:8k.
REQ-019 FSM states SHALL be IDLE, ACCESS, DATA, WRITE; ram_we, ram_addr, ram_din registered.
REQ-020 Word store: accept at edge E0 -> WRITE with ram_we=1; E1 -> IDLE, ack=1 in the following cycle.
REQ-021 Load: E0 -> ACCESS; E1 RAM reads -> DATA; E2 rdata registered, rvalid=1 in following cycle, -> IDLE.
REQ-022 Sub-word store (no macro): read-modify-write; E0 -> ACCESS, E1 -> DATA, E2 merged word into ram_din with ram_we=1 -> WRITE, E3 -> IDLE, ack following cycle.
REQ-023 Loads B/H SHALL sign-extend, BU/HU zero-extend, W pass through.
REQ-024 Half with addr[0]=1, word with addr[1:0]!=0, or funct3 outside REQ-007 (or BU/HU with we=1) SHALL pulse err next cycle, no RAM write, stay IDLE.
REQ-025 ready SHALL be 1 in the ack/rvalid cycle; a back-to-back request is accepted that cycle.
REQ-026 req while ready=0 SHALL be ignored; the core holds it.
REQ-027 ram_we SHALL be 1 for exactly one cycle per store and never for loads or errors.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, ram_we=0, ram_addr=0, ram_din=0, ack=rvalid=err=0, rdata=0, ready=1 after release.
REQ-029 Reset during any non-IDLE state SHALL abandon the operation; no pending write reaches the RAM.

Configuration
REQ-030 Macro LSU_BYTE_WE_EN defined: extra output ram_be[3:0]; sub-word stores issue one write with lanes shifted and ram_be set, latency as REQ-020; word store ram_be=4'hF; loads ram_be=0.
REQ-031 Macro undefined: no ram_be port; sub-word stores use REQ-022.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 enum, the FSM state enum and lane constants.
REQ-033 Combinational sub-module lsu_align SHALL perform load extraction/extension and store lane merge.

Verification
REQ-034 SW 0x34 data 0xA2345678, then LW 0x34 -> ack 2 cycles after accept; rvalid 3 cycles after accept, rdata 0xA2345678.
REQ-035 SB 0x35 data 0xFF onto that word -> RAM[13]=0xA234FF78; LB 0x35 -> 0xFFFFFFFF; LBU 0x35 -> 0x000000FF.
REQ-036 SW 0x40 data 0, SH 0x42 data 0x8001 -> RAM[16]=0x80010000; LH 0x42 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-037 LW 0x41 and SH 0x43 -> err pulse each, ram_we never 1, ready stays 1.
REQ-038 rst_n low during WRITE of an SB to 0x35 -> ram_we falls immediately, RAM[13] unchanged; SW 0x1000 afterwards writes RAM[0].
